// File: rtl/or16_response_checker_pkg.sv
// Shared types and default sizes for the OR16 response checker.
package or16_response_checker_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/or16_compare_stage.sv
// Registers an accepted sample with its index and the OR-mismatch verdict for it.
module or16_compare_stage
  import or16_response_checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  input  logic [CNT_W-1:0] idx,
  output logic             s1_valid,
  output logic             s1_mismatch,
  output logic [WIDTH-1:0] s1_a,
  output logic [WIDTH-1:0] s1_b,
  output logic [WIDTH-1:0] s1_y,
  output logic [CNT_W-1:0] s1_idx
);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_mismatch <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_y        <= '0;
      s1_idx      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_mismatch <= (y != (a | b));
        s1_a        <= a;
        s1_b        <= b;
        s1_y        <= y;
        s1_idx      <= idx;
      end
    end
  end

endmodule

// File: rtl/or16_response_checker.sv
// Checks a stream of (a, b, y) samples against y == a | b and tallies the results.
// Handshake: a sample transfers on any rising edge where in_valid && in_ready; in_ready is high only in RUN.
module or16_response_checker
  import or16_response_checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] expected_count,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_y,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] error_count,
  output logic             err_pulse,
  output logic [CNT_W-1:0] first_err_index,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH-1:0] first_err_y,
  output logic             first_err_valid,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic             accept, last_accept, clear_run;
  logic [CNT_W-1:0] exp_cnt_q, accept_cnt_q;
  logic             s1_valid, s1_mismatch;
  logic [WIDTH-1:0] s1_a, s1_b, s1_y;
  logic [CNT_W-1:0] s1_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (accept_cnt_q == exp_cnt_q - CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    clear_run = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          clear_run = 1'b1;
          state_d   = (expected_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_accept) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The last accepted sample retires from the compare stage this cycle.
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      exp_cnt_q       <= '0;
      accept_cnt_q    <= '0;
      match_count     <= '0;
      error_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_index <= '0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_y     <= '0;
    end else begin
      state_q <= state_d;
      if (clear_run) begin
        exp_cnt_q       <= expected_count;
        accept_cnt_q    <= '0;
        match_count     <= '0;
        error_count     <= '0;
        first_err_valid <= 1'b0;
        first_err_index <= '0;
        first_err_a     <= '0;
        first_err_b     <= '0;
        first_err_y     <= '0;
      end else begin
        if (accept) accept_cnt_q <= sat_inc(accept_cnt_q);
        if (s1_valid) begin
          if (s1_mismatch) begin
            error_count <= sat_inc(error_count);
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_index <= s1_idx;
              first_err_a     <= s1_a;
              first_err_b     <= s1_b;
              first_err_y     <= s1_y;
            end
          end else begin
            match_count <= sat_inc(match_count);
          end
        end
      end
    end
  end

  assign pass      = done & (error_count == '0);
  assign err_pulse = s1_valid & s1_mismatch & ~rst;
  assign dbg_state = state_q;

  or16_compare_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_compare (
    .clk         (clk),
    .rst         (rst),
    .accept      (accept),
    .a           (in_a),
    .b           (in_b),
    .y           (in_y),
    .idx         (accept_cnt_q),
    .s1_valid    (s1_valid),
    .s1_mismatch (s1_mismatch),
    .s1_a        (s1_a),
    .s1_b        (s1_b),
    .s1_y        (s1_y),
    .s1_idx      (s1_idx)
  );

endmodule

// File: tb/tb_or16_response_checker.sv
// Directed bench for or16_response_checker: runs, mismatches, gaps, reset and empty runs.
module tb_or16_response_checker;
  import or16_response_checker_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] expected_count;
  logic             in_valid;
  logic [WIDTH-1:0] in_a, in_b, in_y;
  logic             in_ready, busy, done, pass, err_pulse, first_err_valid;
  logic [CNT_W-1:0] match_count, error_count, first_err_index;
  logic [WIDTH-1:0] first_err_a, first_err_b, first_err_y;
  state_t           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int pulse_mark;

  always #5 clk = ~clk;

  or16_response_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .expected_count  (expected_count),
    .in_valid        (in_valid),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_y            (in_y),
    .in_ready        (in_ready),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .match_count     (match_count),
    .error_count     (error_count),
    .err_pulse       (err_pulse),
    .first_err_index (first_err_index),
    .first_err_a     (first_err_a),
    .first_err_b     (first_err_b),
    .first_err_y     (first_err_y),
    .first_err_valid (first_err_valid),
    .dbg_state       (dbg_state)
  );

  always @(negedge clk) if (err_pulse === 1'b1) pulse_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] y);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_y = y;
    step();
    in_valid = 1'b0;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] n);
    start = 1'b1;
    expected_count = n;
    step();
    start = 1'b0;
    expected_count = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; expected_count = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_y = '0;
    step(); step();
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_busy_done_pass", {61'd0, busy, done, pass}, 64'd0);
    chk("rst_counts", {match_count, error_count}, 64'd0);
    chk("rst_first_err_valid", 64'(first_err_valid), 64'd0);
    rst = 1'b0;

    // Samples offered in IDLE must be ignored.
    send(16'h0001, 16'h0001, 16'h0000);
    send(16'h0002, 16'h0000, 16'h0000);
    chk("idle_ready", 64'(in_ready), 64'd0);
    chk("idle_counts", {match_count, error_count}, 64'd0);

    // Four clean vectors.
    start_run(4);
    chk("t1_state_run", 64'(dbg_state), 64'(ST_RUN));
    chk("t1_ready_busy", {62'd0, in_ready, busy}, 64'd3);
    send(16'h0000, 16'h0000, 16'h0000);
    send(16'h00FF, 16'hFF00, 16'hFFFF);
    send(16'h1234, 16'h0001, 16'h1235);
    send(16'hFFFF, 16'h0000, 16'hFFFF);
    chk("t1_state_drain", 64'(dbg_state), 64'(ST_DRAIN));
    chk("t1_drain_ready", 64'(in_ready), 64'd0);
    step();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_match", 64'(match_count), 64'd4);
    chk("t1_error", 64'(error_count), 64'd0);
    chk("t1_fev", 64'(first_err_valid), 64'd0);

    // One mismatch at index 1.
    pulse_mark = pulse_cnt;
    start_run(3);
    chk("t2_cleared_match", 64'(match_count), 64'd0);
    send(16'h0001, 16'h0002, 16'h0003);
    chk("t2_no_pulse_v0", 64'(err_pulse), 64'd0);
    send(16'h0F0F, 16'hF0F0, 16'hFFFE);
    chk("t2_pulse_v1", 64'(err_pulse), 64'd1);
    send(16'h4000, 16'h0004, 16'h4004);
    step();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_pass", 64'(pass), 64'd0);
    chk("t2_error", 64'(error_count), 64'd1);
    chk("t2_match", 64'(match_count), 64'd2);
    chk("t2_fe_index", 64'(first_err_index), 64'd1);
    chk("t2_fe_a", 64'(first_err_a), 64'h0F0F);
    chk("t2_fe_b", 64'(first_err_b), 64'hF0F0);
    chk("t2_fe_y", 64'(first_err_y), 64'hFFFE);
    chk("t2_fev", 64'(first_err_valid), 64'd1);
    chk("t2_pulse_count", 64'(pulse_cnt - pulse_mark), 64'd1);

    // Mismatches at indices 0 and 2; the first capture must be retained.
    start_run(3);
    send(16'h0001, 16'h0002, 16'h0000);
    send(16'h0100, 16'h0200, 16'h0300);
    send(16'hAAAA, 16'h5555, 16'h0000);
    step();
    chk("t3_error", 64'(error_count), 64'd2);
    chk("t3_match", 64'(match_count), 64'd1);
    chk("t3_fe_index", 64'(first_err_index), 64'd0);
    chk("t3_fe_a", 64'(first_err_a), 64'h0001);
    chk("t3_fe_y", 64'(first_err_y), 64'h0000);

    // Samples in DONE ignored; gaps in RUN; start in RUN ignored; samples in DRAIN ignored.
    in_valid = 1'b1; in_a = 16'hF000; in_b = 16'h000F; in_y = 16'h0000;
    step(); step();
    chk("t4_done_hold_error", 64'(error_count), 64'd2);
    chk("t4_done_hold_state", 64'(dbg_state), 64'(ST_DONE));
    start_run(3);
    in_valid = 1'b0;
    chk("t4_cleared_error", 64'(error_count), 64'd0);
    step();
    send(16'h0101, 16'h1010, 16'h1111);
    start = 1'b1; expected_count = 1;
    step();
    start = 1'b0; expected_count = '0;
    send(16'h8000, 16'h0001, 16'h8001);
    chk("t4_still_run", 64'(dbg_state), 64'(ST_RUN));
    chk("t4_still_ready", 64'(in_ready), 64'd1);
    step(); step();
    send(16'h7FFF, 16'h8000, 16'hFFFF);
    chk("t4_drain", 64'(dbg_state), 64'(ST_DRAIN));
    in_valid = 1'b1; in_a = 16'h0F00; in_b = 16'h00F0; in_y = 16'h0000;
    step();
    in_valid = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_match", 64'(match_count), 64'd3);
    chk("t4_error", 64'(error_count), 64'd0);
    chk("t4_pass", 64'(pass), 64'd1);

    // Reset mid-run after 2 of 5 vectors, both mismatching.
    pulse_mark = pulse_cnt;
    start_run(5);
    send(16'h0003, 16'h0004, 16'h0000);
    send(16'h0010, 16'h0020, 16'h0031);
    chk("t5_pre_error", 64'(error_count), 64'd1);
    chk("t5_pre_fev", 64'(first_err_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_pulse_gated", 64'(err_pulse), 64'd0);
    step();
    chk("t5_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("t5_flags", {59'd0, busy, done, pass, err_pulse, in_ready}, 64'd0);
    chk("t5_counts", {match_count, error_count}, 64'd0);
    chk("t5_fe", {first_err_index, first_err_a, first_err_b}, 64'd0);
    chk("t5_fe_y_valid", {47'd0, first_err_y, first_err_valid}, 64'd0);
    start = 1'b1; expected_count = 2;
    step();
    chk("t5_rst_over_start", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0; start = 1'b0; expected_count = '0;
    step();
    chk("t5_pulse_count", 64'(pulse_cnt - pulse_mark), 64'd1);
    start_run(2);
    send(16'h0005, 16'h000A, 16'h000F);
    send(16'h1000, 16'h2000, 16'h3000);
    step();
    chk("t5_rerun_done", 64'(done), 64'd1);
    chk("t5_rerun_match", 64'(match_count), 64'd2);
    chk("t5_rerun_pass", 64'(pass), 64'd1);

    // Empty run goes straight to DONE and clears the previous tallies.
    start_run(0);
    chk("t6_state", 64'(dbg_state), 64'(ST_DONE));
    chk("t6_pass_done", {62'd0, done, pass}, 64'd3);
    chk("t6_counts", {match_count, error_count}, 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    step();
    chk("t6_hold", 64'(dbg_state), 64'(ST_DONE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/or16_response_checker.md
OR16_RESPONSE_CHECKER -- requirements
Module: or16_response_checker

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width of the unit under check.
REQ-002 Parameter CNT_W, default 32, width of all vector counters and indices.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous to clk and active-high.
REQ-005 start  input  1  one-cycle pulse; arms a checking run.
REQ-006 expected_count  input  CNT_W  vectors in the run; sampled on the start cycle.
REQ-007 in_valid  input  1  a, b, y sample present this cycle.
REQ-008 in_a, in_b  input  WIDTH  operands driven to the OR unit.
REQ-009 in_y  input  WIDTH  OR-unit response to in_a, in_b.
REQ-010 in_ready  output  1  checker accepts a sample this cycle.
REQ-011 busy  output  1  run in progress (RUN or DRAIN).
REQ-012 done  output  1  run complete; results stable.
REQ-013 pass  output  1  valid while done; 1 when error_count == 0.
REQ-014 match_count, error_count  output  CNT_W  compared-vector tallies.
REQ-015 err_pulse  output  1  one-cycle pulse per mismatching vector.
REQ-016 first_err_index  output  CNT_W  zero-based index of the first mismatching vector.
REQ-017 first_err_a, first_err_b, first_err_y  output  WIDTH  captured first failing sample.
REQ-018 first_err_valid  output  1  the first_err_* fields hold a capture.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start.
REQ-020 In RUN, in_ready shall be 1; elsewhere in_ready shall be 0; samples with in_ready=0 are ignored.
REQ-021 Accept = in_valid & in_ready; accepted sample and its index shall be registered (stage 1).
REQ-022 Stage 2, one cycle after acceptance: mismatch = (y != (a | b)) over all WIDTH bits; update match_count or error_count and assert err_pulse that cycle.
REQ-023 On the first mismatch of a run, capture index/a/b/y and set first_err_valid; later mismatches shall not overwrite.
REQ-024 RUN->DRAIN on the cycle the expected_count-th sample is accepted; DRAIN->DONE after one cycle, when stage 2 has retired.
REQ-025 expected_count == 0: start shall move IDLE->DONE directly with pass=1 and all counts 0.
REQ-026 DONE holds all results until start (clears counts and first_err_*, enters RUN) or rst.
REQ-027 start while in RUN or DRAIN shall be ignored.
REQ-028 Counters shall saturate at all-ones, never wrap.
REQ-029 busy = (state == RUN or DRAIN); done = (state == DONE).

Reset
REQ-030 rst (synchronous, active-high) shall force IDLE, all counters, first_err_* and flags to 0, including mid-run; the pipeline stage shall be invalidated so no err_pulse or counter update follows.
REQ-031 rst shall override a coincident start.

Structure
REQ-032 Shared package holds the FSM state enum and default WIDTH/CNT_W constants.
REQ-033 One sub-module, or16_compare_stage: registered compare producing mismatch flag; no further hierarchy.

Verification
REQ-034 expected_count=4, vectors (0x0000,0x0000,0x0000), (0x00FF,0xFF00,0xFFFF), (0x1234,0x0001,0x1235), (0xFFFF,0x0000,0xFFFF) -> done, pass=1, match_count=4, error_count=0.
REQ-035 expected_count=3, second vector (0x0F0F,0xF0F0,0xFFFE) -> err_pulse once, error_count=1, first_err_index=1, first_err_y=0xFFFE, pass=0.
REQ-036 Two mismatches at indices 0 and 2 -> first_err_index=0 retained, error_count=2.
REQ-037 in_valid toggling with gaps during RUN, in_valid asserted in IDLE/DONE -> only RUN samples counted; done after exactly expected_count accepts.
REQ-038 rst asserted mid-run after 2 of 5 vectors -> next cycle IDLE, all outputs 0, no err_pulse; new start runs cleanly.
REQ-039 expected_count=0 start -> DONE next cycle, pass=1, counts 0.
